// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 front-end constants and types
package rv32_pkg;

  localparam logic [31:0] RV32_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_fetch_fifo.sv
// rtl/rv32_fetch_fifo.sv - small synchronous FIFO with flush and occupancy count
module rv32_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Flush wins over a same-cycle push or pop.
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !flush) |-> (count_q < CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (pop && !flush) |-> (count_q != '0));

endmodule

// File: rtl/rv32_fetch.sv
// rtl/rv32_fetch.sv - IF stage: PC owner, credit-limited imem fetch, fetch queue toward ID
module rv32_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(FQ_DEPTH + 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CW-1:0] fq_count, tag_count;
  logic [31:0]   tag_head;
  fetch_entry_t  fq_head, fq_push_data;
  logic          pop, credit, accept, rsp_keep, fq_push;
  logic [CW:0]   in_use;

  always_comb begin
    if_valid       = (fq_count != '0) & ~redirect_valid;
    pop            = if_valid & id_ready;
    // A slot freed by this cycle's pop can be re-used immediately: one fetch per cycle.
    in_use         = {1'b0, fq_count} + {1'b0, outstanding_q} - (CW+1)'(pop);
    credit         = in_use < (CW+1)'(FQ_DEPTH);
    imem_req_valid = credit & ~redirect_valid;
    accept         = imem_req_valid & imem_req_ready;
    rsp_keep       = imem_rsp_valid & (drop_cnt_q == '0);
    fq_push        = rsp_keep & ~redirect_valid;
    fq_push_data   = '{pc: tag_head, instr: imem_rsp_data};
    if_pc          = if_valid ? fq_head.pc : 32'h0;
    if_instr       = if_valid ? fq_head.instr : RV32_NOP;

    outstanding_d  = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    pc_d           = pc_q;
    drop_cnt_d     = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      drop_cnt_d = outstanding_d;
    end else begin
      if (accept) begin
        pc_d = pc_q + 32'd4;
      end
      if (imem_rsp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign imem_req_addr = pc_q;

  // Tags of live requests only; requests orphaned by a redirect never pop it.
  rv32_fetch_fifo #(.WIDTH(32), .DEPTH(FQ_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (accept),
    .push_data (pc_q),
    .pop       (rsp_keep),
    .head_data (tag_head),
    .count     (tag_count)
  );

  rv32_fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(FQ_DEPTH)) u_fetch_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (pop),
    .head_data (fq_head),
    .count     (fq_count)
  );

  a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outstanding_q != '0));
  a_tags_bounded: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count <= outstanding_q);

endmodule

// File: tb/tb_rv32_fetch.sv
// tb/tb_rv32_fetch.sv - randomized scoreboard bench for rv32_fetch with program-order reference model
module tb_rv32_fetch;
  import rv32_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          FQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_ready = 1'b1;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  rv32_fetch #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  fetch_entry_t exp_q[$];
  pend_t        pend_q[$];
  logic [31:0]  popped_pc[$];
  logic [31:0]  fetch_pc = RESET_PC;
  logic [31:0]  hold_addr = 32'h0;
  bit           hold_v = 1'b0;
  int           cyc = 0;
  int           lat_min = 1, lat_max = 1;
  int           n_pass = 0, n_total = 0;

  bit          k_id = 1'b1, k_rdy = 1'b1, k_redir = 1'b0;
  logic [31:0] k_rpc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock cycle: apply knobs and imem response at negedge, observe request side at +1.
  task automatic step();
    @(negedge clk);
    cyc++;
    rst_n          = 1'b1;
    id_ready       = k_id;
    imem_req_ready = k_rdy;
    redirect_valid = k_redir;
    redirect_pc    = k_rpc;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = pend_q[0].data;
      void'(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (hold_v && !redirect_valid) begin
      check("req_hold_valid", imem_req_valid, 1);
      check("req_hold_addr", imem_req_addr, hold_addr);
    end
    if (redirect_valid) begin
      check("redir_no_req", imem_req_valid, 0);
      check("redir_no_if_valid", if_valid, 0);
      exp_q.delete();
      popped_pc.delete();
      fetch_pc = {redirect_pc[31:2], 2'b00};
    end else if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, fetch_pc);
      check("credit_limit", (exp_q.size() - int'(if_valid && id_ready)) < FQ_DEPTH, 1);
      exp_q.push_back('{pc: fetch_pc, instr: mem_word(fetch_pc)});
      pend_q.push_back('{data: mem_word(imem_req_addr),
                         due: cyc + int'($urandom_range(lat_max, lat_min))});
      fetch_pc = fetch_pc + 32'd4;
    end
    hold_v    = imem_req_valid && !imem_req_ready && !redirect_valid;
    hold_addr = imem_req_addr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    id_ready       = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    exp_q.delete();
    pend_q.delete();
    popped_pc.delete();
    fetch_pc = RESET_PC;
    hold_v   = 1'b0;
    k_id = 1'b1; k_rdy = 1'b1; k_redir = 1'b0;
    @(negedge clk);
    #1;
    check("rst_req_valid", imem_req_valid, 1);
    check("rst_req_addr", imem_req_addr, RESET_PC);
    check("rst_if_valid", if_valid, 0);
    check("rst_if_pc", if_pc, 32'h0);
    check("rst_if_instr", if_instr, RV32_NOP);
  endtask

  task automatic wait_pops(input int n, input string name);
    int b = 0;
    while (popped_pc.size() < n && b < 30) begin
      step();
      b++;
    end
    if (popped_pc.size() < n) check({name, "_timeout"}, popped_pc.size(), n);
  endtask

  // Monitor: every ID handshake must deliver the next program-order entry.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && if_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_pop: got pc %h expected no instruction (cycle %0d)", if_pc, cyc);
        end else begin
          fetch_entry_t e;
          e = exp_q.pop_front();
          check("if_pc", if_pc, e.pc);
          check("if_instr", if_instr, e.instr);
        end
        popped_pc.push_back(if_pc);
      end else if (!if_valid) begin
        check("idle_nop", if_instr, RV32_NOP);
      end
    end
  end

  initial begin
    do_reset();

    // Streaming with 1-cycle imem: one instruction per cycle from cycle 2.
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      check("t1_req_every_cycle", imem_req_valid, 1);
      if (i >= 2) check("t1_if_valid_cont", if_valid, 1);
    end

    // ID stall then resume.
    k_id = 1'b0;
    for (int i = 0; i < 5; i++) step();
    k_id = 1'b1;
    for (int i = 0; i < 10; i++) step();

    // Redirect with two responses in flight.
    do_reset();
    lat_min = 3; lat_max = 3;
    step();
    step();
    step();
    k_redir = 1'b1; k_rpc = 32'h0000_0100;
    step();
    k_redir = 1'b0;
    lat_min = 1; lat_max = 1;
    wait_pops(2, "t3");
    if (popped_pc.size() >= 2) begin
      check("t3_first_pc", popped_pc[0], 32'h0000_0100);
      check("t3_second_pc", popped_pc[1], 32'h0000_0104);
    end

    // Misaligned redirect target.
    k_redir = 1'b1; k_rpc = 32'h0000_0203;
    step();
    check("t4_if_valid_redirect", if_valid, 0);
    k_redir = 1'b0;
    step();
    check("t4_req_valid", imem_req_valid, 1);
    check("t4_req_addr", imem_req_addr, 32'h0000_0200);
    wait_pops(1, "t4");

    // imem back-pressure holds the address.
    do_reset();
    step();
    step();
    k_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_addr_held", imem_req_addr, 32'h0000_0008);
    end
    k_rdy = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // PC wrap.
    k_redir = 1'b1; k_rpc = 32'hFFFF_FFF8;
    step();
    k_redir = 1'b0;
    wait_pops(4, "wrap");
    if (popped_pc.size() >= 4) begin
      check("wrap_pc2", popped_pc[2], 32'h0000_0000);
      check("wrap_pc3", popped_pc[3], 32'h0000_0004);
    end

    // Reset mid-stream with a full queue.
    k_id = 1'b0;
    for (int i = 0; i < 6; i++) step();
    do_reset();

    // Randomized traffic.
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      k_id    = ($urandom_range(99, 0) < 75);
      k_rdy   = ($urandom_range(99, 0) < 70);
      k_redir = ($urandom_range(99, 0) < 4);
      k_rpc   = ($urandom_range(9, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0)))
                                            : $urandom;
      step();
    end

    // Drain.
    k_id = 1'b1; k_rdy = 1'b0; k_redir = 1'b0;
    for (int b = 0; b < 50 && (exp_q.size() > 0 || pend_q.size() > 0); b++) step();
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
